matrix_line_packer: RTL and testbench

- Upstream feeder for the dual-port matrix line memory.
- Accepts a valid/ready stream of matrix elements and packs LANES = DATA_WIDTH/ELEM_WIDTH elements into one DATA_WIDTH-bit line.
- Writes each full line into consecutive memory addresses starting at a programmed base.
- Runs one job per start pulse and signals completion with a done pulse.

---
 rtl/matrix_line_packer_if.sv | 25 ++
 rtl/matrix_line_packer.sv | 170 +++++++++++++++++
 tb/tb_matrix_line_packer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_line_packer_if.sv
// Element stream and line-memory write bus for matrix_line_packer.
// slave: packer side (consumes s_*, drives s_ready and w_*); master: feeder/memory side.
interface matrix_line_packer_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 10,
  parameter int ELEM_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [ELEM_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, w_en, w_addr, w_data
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, w_en, w_addr, w_data
  );
endinterface

// File: rtl/matrix_line_packer.sv
// Packs DATA_WIDTH/ELEM_WIDTH stream elements into one memory line per write.
// Ports: clk, rst_n, bus (stream in / line write out), start/base_addr/num_lines
// job control, busy/done status. MATRIX_PACKER_ZERO_PAD_EN enables s_last
// early line end plus the lines_written output.
module matrix_line_packer #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 10,
  parameter int ELEM_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_line_packer_if.slave   bus,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_lines,
`ifdef MATRIX_PACKER_ZERO_PAD_EN
  output logic [ADDR_WIDTH:0]   lines_written,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int LANES = DATA_WIDTH / ELEM_WIDTH;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH:0]   line_q, line_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  end_line;
  logic                  fin;

`ifdef MATRIX_PACKER_ZERO_PAD_EN
  logic                  last_q, last_d;
  logic [ADDR_WIDTH:0]   lw_q, lw_d;
  assign lines_written = lw_q;
`else
  logic                  unused_s_last;
  assign unused_s_last = bus.s_last;
`endif

  assign bus.s_ready = (state_q == S_FILL);
  assign bus.w_en    = w_en_q;
  assign bus.w_addr  = w_addr_q;
  assign bus.w_data  = w_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    line_d   = line_q;
    lane_d   = lane_q;
    buf_d    = buf_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    end_line = 1'b0;
    fin      = 1'b0;
`ifdef MATRIX_PACKER_ZERO_PAD_EN
    last_d   = last_q;
    lw_d     = lw_q;
`endif
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          base_d = base_addr;
          num_d  = num_lines;
          line_d = '0;
          lane_d = '0;
          buf_d  = '0;
`ifdef MATRIX_PACKER_ZERO_PAD_EN
          last_d = 1'b0;
          lw_d   = '0;
`endif
          state_d = (num_lines == '0) ? S_DONE : S_FILL;
        end
      end
      (state_q == S_FILL): begin
        if (bus.s_valid) begin
          buf_d[lane_q*ELEM_WIDTH +: ELEM_WIDTH] = bus.s_data;
          lane_d   = lane_q + 1'b1;
          end_line = (lane_q == LAST_LANE);
`ifdef MATRIX_PACKER_ZERO_PAD_EN
          // Untouched upper lanes are already zero: buffer clears per line.
          end_line = end_line | bus.s_last;
          last_d   = bus.s_last;
`endif
          if (end_line) begin
            state_d  = S_WRITE;
            lane_d   = '0;
            w_data_d = buf_d;
            w_addr_d = base_q + line_q[ADDR_WIDTH-1:0];
          end
        end
      end
      (state_q == S_WRITE): begin
        line_d = line_q + 1'b1;
        lane_d = '0;
        buf_d  = '0;
        fin    = (line_d == num_q);
`ifdef MATRIX_PACKER_ZERO_PAD_EN
        lw_d = lw_q + 1'b1;
        fin  = fin | last_q;
`endif
        state_d = fin ? S_DONE : S_FILL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    w_en_d = (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      num_q    <= '0;
      line_q   <= '0;
      lane_q   <= '0;
      buf_q    <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      num_q    <= num_d;
      line_q   <= line_d;
      lane_q   <= lane_d;
      buf_q    <= buf_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef MATRIX_PACKER_ZERO_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
      lw_q   <= '0;
    end else begin
      last_q <= last_d;
      lw_q   <= lw_d;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_line_packer.sv
// Scoreboard bench for matrix_line_packer: stimulus queues expected writes,
// a negedge monitor pops and compares each w_en beat.
module tb_matrix_line_packer;

  localparam int DW = 256;
  localparam int AW = 10;
  localparam int EW = 16;
  localparam int LANES = DW / EW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_lines;
  logic          busy;
  logic          done;
`ifdef MATRIX_PACKER_ZERO_PAD_EN
  logic [AW:0]   lines_written;
`endif

  matrix_line_packer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ELEM_WIDTH(EW)) bus ();

  matrix_line_packer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ELEM_WIDTH(EW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .start(start),
    .base_addr(base_addr),
    .num_lines(num_lines),
`ifdef MATRIX_PACKER_ZERO_PAD_EN
    .lines_written(lines_written),
`endif
    .busy(busy),
    .done(done)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  wr_count = 0;
  int  last_wr_cyc = 0;
  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write beat is compared against the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.w_en) begin
      wr_count++;
      last_wr_cyc = cyc;
      chk("s_ready_in_write", DW'(bus.s_ready), DW'(0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h expected none", bus.w_addr);
      end else begin
        e = exp_q.pop_front();
        chk("w_addr", DW'(bus.w_addr), DW'(e.addr));
        chk("w_data", bus.w_data, e.data);
      end
    end
  end

  task automatic expect_line(input logic [AW-1:0] a, input logic [15:0] first,
                             input int n);
    wr_t e;
    e.addr = a;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[i*EW +: EW] = first + 16'(i);
    exp_q.push_back(e);
  endtask

  task automatic push_elem(input logic [15:0] d, input logic last, input bit gap);
    int t;
    t = 0;
    if (gap) begin
      bus.s_valid = 1'b0;
      @(negedge clk);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic stream(input logic [15:0] first, input int n, input bit gap);
    for (int i = 0; i < n; i++) push_elem(first + 16'(i), 1'b0, gap);
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] n);
    wr_count = 0;
    start = 1'b1;
    base_addr = b;
    num_lines = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_wr);
    int t;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done_seen"}, DW'(done), DW'(1));
    chk({name, "_done_lat"}, DW'(cyc - last_wr_cyc), DW'(1));
    chk({name, "_writes"}, DW'(wr_count), DW'(exp_wr));
    @(negedge clk);
    chk({name, "_done_pulse"}, DW'(done), DW'(0));
    chk({name, "_busy_off"}, DW'(busy), DW'(0));
  endtask

  initial begin
    bit saw_done;
    bit saw_ready;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_lines = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_s_ready", DW'(bus.s_ready), DW'(0));
    chk("rst_w_en", DW'(bus.w_en), DW'(0));
    chk("rst_w_addr", DW'(bus.w_addr), DW'(0));
    chk("rst_w_data", bus.w_data, DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Two lines, continuous stream.
    expect_line(10'h010, 16'h0001, LANES);
    expect_line(10'h011, 16'h0011, LANES);
    start_job(10'h010, 11'd2);
    chk("busy_after_start", DW'(busy), DW'(1));
    stream(16'h0001, 2 * LANES, 1'b0);
    wait_done("two_lines", 2);
    chk("hold_w_addr", DW'(bus.w_addr), DW'(10'h011));

    // Toggling s_valid, single line.
    expect_line(10'h100, 16'h00a0, LANES);
    start_job(10'h100, 11'd1);
    stream(16'h00a0, LANES, 1'b1);
    wait_done("gapped", 1);

    // Address wrap at the top of memory.
    expect_line(10'h3ff, 16'h0100, LANES);
    expect_line(10'h000, 16'h0110, LANES);
    start_job(10'h3ff, 11'd2);
    stream(16'h0100, 2 * LANES, 1'b0);
    wait_done("wrap", 2);

    // Zero-line job: done with no writes and no s_ready.
    start_job(10'h055, 11'd0);
    saw_done = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1'b1;
      if (bus.s_ready) saw_ready = 1'b1;
      @(negedge clk);
    end
    chk("zero_done", DW'(saw_done), DW'(1));
    chk("zero_ready", DW'(saw_ready), DW'(0));
    chk("zero_writes", DW'(wr_count), DW'(0));

    // Reset in the middle of a line.
    start_job(10'h050, 11'd1);
    stream(16'h0700, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_s_ready", DW'(bus.s_ready), DW'(0));
    chk("mid_rst_w_en", DW'(bus.w_en), DW'(0));
    chk("mid_rst_w_addr", DW'(bus.w_addr), DW'(0));
    chk("mid_rst_w_data", bus.w_data, DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_line(10'h020, 16'h0200, LANES);
    start_job(10'h020, 11'd1);
    stream(16'h0200, LANES, 1'b0);
    wait_done("after_rst", 1);

`ifdef MATRIX_PACKER_ZERO_PAD_EN
    // s_last on the fifth element pads the line and ends the job.
    expect_line(10'h040, 16'h0001, 5);
    start_job(10'h040, 11'd4);
    stream(16'h0001, 4, 1'b0);
    push_elem(16'h0005, 1'b1, 1'b0);
    while (!done && !bus.w_en) @(negedge clk);
    wait_done("zero_pad", 1);
    chk("lines_written", DW'(lines_written), DW'(1));
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", DW'(exp_q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
